// File: rtl/fixed_div_arbiter.sv
// Round-robin front end that shares one iterative fixed-point divider among NUM_REQ clients.
// Optional macro FIXED_DIV_ARB_INF_CLAMP_EN maps an infinite quotient (max positive Fixed) to zero.
module fixed_div_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int FIXED_W = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*FIXED_W-1:0] req_a,
  input  logic [NUM_REQ*FIXED_W-1:0] req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [FIXED_W-1:0]         resp_q,
  output logic                       busy,
  output logic                       div_strobe,
  output logic [FIXED_W-1:0]         div_a,
  output logic [FIXED_W-1:0]         div_b,
  input  logic                       div_valid,
  input  logic [FIXED_W-1:0]         div_q
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   owner;
  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;
  logic [FIXED_W-1:0] a_arr [NUM_REQ];
  logic [FIXED_W-1:0] b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*FIXED_W +: FIXED_W];
    assign b_arr[i] = req_b[i*FIXED_W +: FIXED_W];
  end

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

  function automatic logic [FIXED_W-1:0] clamp_q(input logic [FIXED_W-1:0] q);
`ifdef FIXED_DIV_ARB_INF_CLAMP_EN
    // A reciprocal of zero comes back as +infinity; clients prefer a clean zero.
    return (q == {1'b0, {(FIXED_W-1){1'b1}}}) ? '0 : q;
`else
    return q;
`endif
  endfunction

  // Scan from the highest offset down so the lowest offset from rr_ptr overwrites and wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(rr_ptr, k)]) begin
        grant_valid = 1'b1;
        grant_id    = wrap_idx(rr_ptr, k);
      end
    end
  end

  assign req_ready = (state == S_IDLE && grant_valid) ? onehot(grant_id) : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      div_strobe <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      resp_valid <= '0;
      resp_q     <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      div_strobe <= 1'b0;
      resp_valid <= '0;
      resp_q     <= '0;
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            owner      <= grant_id;
            div_a      <= a_arr[grant_id];
            div_b      <= b_arr[grant_id];
            rr_ptr     <= wrap_idx(grant_id, 1);
            div_strobe <= 1'b1;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        // Any div_valid seen during the strobe cycle belongs to an older operation.
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (div_valid) begin
            resp_valid <= onehot(owner);
            resp_q     <= clamp_q(div_q);
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          busy  <= 1'b0;
          div_a <= '0;
          div_b <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_div_arbiter.sv
// Directed bench for fixed_div_arbiter: the divider is driven by hand, Fixed is Q16.16.
// Define FIXED_DIV_ARB_INF_CLAMP_EN here as well when building the clamped variant.
module tb_fixed_div_arbiter;
  localparam int NR = 3;
  localparam int FW = 32;
  localparam logic [FW-1:0] ONE  = 32'h0001_0000;
  localparam logic [FW-1:0] TWO  = 32'h0002_0000;
  localparam logic [FW-1:0] HALF = 32'h0000_8000;
  localparam logic [FW-1:0] INF  = 32'h7FFF_FFFF;
`ifdef FIXED_DIV_ARB_INF_CLAMP_EN
  localparam logic [FW-1:0] INF_RESP = 32'h0000_0000;
`else
  localparam logic [FW-1:0] INF_RESP = 32'h7FFF_FFFF;
`endif

  logic              clk = 1'b0;
  logic              resetn;
  logic [NR-1:0]     req_valid;
  logic [NR*FW-1:0]  req_a, req_b;
  logic [NR-1:0]     req_ready, resp_valid;
  logic [FW-1:0]     resp_q, div_a, div_b, div_q;
  logic              busy, div_strobe, div_valid;

  logic [FW-1:0] exp_a [NR] = '{32'h0001_0000, 32'h0002_0000, 32'h0004_0000};
  logic [FW-1:0] exp_b [NR] = '{32'h0003_0000, 32'h0005_0000, 32'h0006_0000};

  int n_checks = 0;
  int n_fail   = 0;

  fixed_div_arbiter #(.NUM_REQ(NR), .FIXED_W(FW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_q(resp_q), .busy(busy),
    .div_strobe(div_strobe), .div_a(div_a), .div_b(div_b),
    .div_valid(div_valid), .div_q(div_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [FW-1:0] a, input logic [FW-1:0] b);
    req_a[i*FW +: FW] = a;
    req_b[i*FW +: FW] = b;
  endtask

  // Entered right after the edge into ISSUE; returns during the RESP cycle.
  task automatic run_txn(input int lat, input logic [FW-1:0] q, input logic [FW-1:0] exp_q,
                         input logic [NR-1:0] own, input logic [FW-1:0] ea,
                         input logic [FW-1:0] eb, input string tag);
    #1;
    check({tag, " strobe"}, FW'(div_strobe), 1);
    check({tag, " ready_issue"}, FW'(req_ready), 0);
    check({tag, " div_a"}, div_a, ea);
    check({tag, " div_b"}, div_b, eb);
    check({tag, " busy_issue"}, FW'(busy), 1);
    for (int k = 1; k < lat; k++) begin
      tick();
      check({tag, " strobe_wait"}, FW'(div_strobe), 0);
      check({tag, " div_a_hold"}, div_a, ea);
    end
    tick();
    div_valid = 1'b1;
    div_q     = q;
    #1;
    check({tag, " resp_early"}, FW'(resp_valid), 0);
    tick();
    div_valid = 1'b0;
    div_q     = '0;
    #1;
    check({tag, " resp_valid"}, FW'(resp_valid), FW'(own));
    check({tag, " resp_q"}, resp_q, exp_q);
    check({tag, " busy_resp"}, FW'(busy), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    div_valid = 1'b0;
    div_q     = '0;
    tick();
    tick();
    check("rst busy", FW'(busy), 0);
    check("rst resp_valid", FW'(resp_valid), 0);
    check("rst strobe", FW'(div_strobe), 0);
    check("rst div_a", div_a, 0);
    check("rst resp_q", resp_q, 0);
    resetn = 1'b1;
    tick();

    // Single request from client 1, L=5: accept T0, strobe T1, response T7.
    req_valid = 3'b010;
    set_req(1, ONE, TWO);
    #1;
    check("t1 ready", FW'(req_ready), 3'b010);
    check("t1 busy_idle", FW'(busy), 0);
    tick();
    req_valid = '0;
    run_txn(5, HALF, HALF, 3'b010, ONE, TWO, "t1");
    tick();
    check("t1 resp_clear", FW'(resp_valid), 0);
    check("t1 q_clear", resp_q, 0);
    check("t1 busy_done", FW'(busy), 0);
    check("t1 div_a_clear", div_a, 0);

    // All clients asserting from reset, L=4: grants 0,1,2,0 seven cycles apart.
    resetn    = 1'b0;
    req_valid = 3'b111;
    for (int i = 0; i < NR; i++) set_req(i, exp_a[i], exp_b[i]);
    tick();
    resetn = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      check("rr ready", FW'(req_ready), FW'(NR'(1) << (g % NR)));
      tick();
      run_txn(4, 32'h0000_1000 + FW'(g), 32'h0000_1000 + FW'(g), NR'(1) << (g % NR),
              exp_a[g % NR], exp_b[g % NR], "rr");
      tick();
    end

    // Pointer is at 1: grant client 2, then 3'b011 must wrap to client 0.
    req_valid = 3'b100;
    #1;
    check("wrap ready2", FW'(req_ready), 3'b100);
    tick();
    req_valid = '0;
    run_txn(3, 32'h0000_2000, 32'h0000_2000, 3'b100, exp_a[2], exp_b[2], "wrap2");
    tick();
    req_valid = 3'b011;
    #1;
    check("wrap ready0", FW'(req_ready), 3'b001);
    tick();
    req_valid = '0;
    run_txn(2, 32'h0000_3000, 32'h0000_3000, 3'b001, exp_a[0], exp_b[0], "wrap0");
    tick();

    // Spurious div_valid in IDLE and in ISSUE must be ignored.
    div_valid = 1'b1;
    div_q     = 32'hDEAD_0000;
    #1;
    check("spur idle busy", FW'(busy), 0);
    tick();
    div_valid = 1'b0;
    #1;
    check("spur idle resp", FW'(resp_valid), 0);
    check("spur idle busy2", FW'(busy), 0);
    req_valid = 3'b001;
    set_req(0, 32'h0003_0000, ONE);
    #1;
    check("spur ready", FW'(req_ready), 3'b001);
    tick();
    req_valid = '0;
    div_valid = 1'b1;
    div_q     = 32'hBAD0_0000;
    #1;
    check("spur strobe", FW'(div_strobe), 1);
    tick();
    div_valid = 1'b0;
    #1;
    check("spur issue resp", FW'(resp_valid), 0);
    check("spur wait busy", FW'(busy), 1);
    tick();
    div_valid = 1'b1;
    div_q     = 32'h0003_0000;
    #1;
    check("spur wait resp", FW'(resp_valid), 0);
    tick();
    div_valid = 1'b0;
    #1;
    check("spur resp_valid", FW'(resp_valid), 3'b001);
    check("spur resp_q", resp_q, 32'h0003_0000);
    tick();
    check("spur done busy", FW'(busy), 0);

    // Reset during WAIT abandons the transaction and rewinds the pointer to 0.
    req_valid = 3'b001;
    #1;
    check("rstw ready", FW'(req_ready), 3'b001);
    tick();
    req_valid = '0;
    tick();
    check("rstw busy_wait", FW'(busy), 1);
    resetn = 1'b0;
    #1;
    check("rstw busy", FW'(busy), 0);
    check("rstw div_a", div_a, 0);
    check("rstw div_b", div_b, 0);
    check("rstw strobe", FW'(div_strobe), 0);
    check("rstw resp", FW'(resp_valid), 0);
    tick();
    resetn    = 1'b1;
    div_valid = 1'b1;
    div_q     = 32'h0000_0123;
    #1;
    check("rstw late busy", FW'(busy), 0);
    tick();
    div_valid = 1'b0;
    #1;
    check("rstw late resp", FW'(resp_valid), 0);
    check("rstw late q", resp_q, 0);
    req_valid = 3'b111;
    #1;
    check("rstw ptr0", FW'(req_ready), 3'b001);
    tick();
    req_valid = '0;
    run_txn(2, 32'h0000_4000, 32'h0000_4000, 3'b001, 32'h0003_0000, ONE, "rstw");
    tick();

    // Divide by zero: divider returns +infinity.
    req_valid = 3'b010;
    set_req(1, ONE, '0);
    #1;
    check("inf ready", FW'(req_ready), 3'b010);
    tick();
    req_valid = '0;
    run_txn(3, INF, INF_RESP, 3'b010, ONE, '0, "inf");
    tick();
    check("inf q_clear", resp_q, 0);
    check("inf busy", FW'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
